// File: rtl/timer_nbits_ctrl.sv
// rtl/timer_nbits_ctrl.sv - programmable N-bit interval timer with shadowed reload and one-shot mode
// Optional prescaler stage is built when TIMER_PRESCALE_EN is defined.
module timer_nbits_ctrl #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      final_value,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active_final;
  logic [WIDTH-1:0] next_final;
  logic             mode_q;
  logic             pre_hit;
  logic             advance;
  logic             wrap;

  // A load on the same cycle as a start or period boundary takes effect immediately.
  assign next_final = load ? final_value : shadow;
  assign wrap       = (count == active_final);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;

  assign pre_hit = (pre_cnt == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (state != RUN || start || stop) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= pre_hit ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  // Without the prescaler every enabled RUN cycle is an advance.
  assign pre_hit = (PRESCALE_W > 0);
`endif

  assign advance = enable && pre_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      tick         <= 1'b0;
      running      <= 1'b0;
      shadow       <= '0;
      active_final <= '0;
      mode_q       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        shadow <= final_value;
      end
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= RUN;
            running      <= 1'b1;
            count        <= '0;
            active_final <= next_final;
            mode_q       <= mode;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            count   <= '0;
          end else if (start) begin
            count        <= '0;
            active_final <= next_final;
            mode_q       <= mode;
          end else if (advance) begin
            if (wrap) begin
              count <= '0;
              tick  <= 1'b1;
              if (mode_q) begin
                state   <= IDLE;
                running <= 1'b0;
              end else begin
                active_final <= next_final;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_nbits_ctrl.sv
// tb/tb_timer_nbits_ctrl.sv - scoreboard bench for timer_nbits_ctrl with a behavioural period model
// Builds with or without TIMER_PRESCALE_EN.
module tb_timer_nbits_ctrl;

  localparam int W       = 8;
  localparam int PW      = 4;
  localparam int PRE_MOD = 1 << PW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] final_value = '0;
`ifdef TIMER_PRESCALE_EN
  logic [PW-1:0] prescale = '0;
`endif
  logic [W-1:0] count;
  logic         tick;
  logic         running;

  timer_nbits_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .load        (load),
    .final_value (final_value),
`ifdef TIMER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .tick        (tick),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tick;
    int run;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference: one period is (limit+1) advances; an advance is an enabled cycle
  // on which the prescale phase has completed.
  int m_run, m_cnt, m_lim, m_oneshot, m_shadow, m_pre, m_tick;

  function automatic void model_reset();
    m_run = 0; m_cnt = 0; m_lim = 0; m_oneshot = 0;
    m_shadow = 0; m_pre = 0; m_tick = 0;
  endfunction

  function automatic void model_step(input bit en, input bit st, input bit sp,
                                     input bit md, input bit ld, input int fv, input int ps);
    int nf;
    int pre_lim;
    bit adv;
    nf = ld ? fv : m_shadow;
    pre_lim = ps;
`ifndef TIMER_PRESCALE_EN
    pre_lim = 0;
`endif
    m_tick = 0;
    if (m_run == 0) begin
      if (st && !sp) begin
        m_run = 1; m_cnt = 0; m_lim = nf; m_oneshot = md; m_pre = 0;
      end
    end else if (sp) begin
      m_run = 0; m_cnt = 0; m_pre = 0;
    end else if (st) begin
      m_cnt = 0; m_lim = nf; m_oneshot = md; m_pre = 0;
    end else if (en) begin
      adv = (m_pre == pre_lim);
      m_pre = adv ? 0 : (m_pre + 1) % PRE_MOD;
      if (adv) begin
        if (m_cnt < m_lim) begin
          m_cnt = m_cnt + 1;
        end else begin
          m_cnt = 0;
          m_tick = 1;
          if (m_oneshot != 0) begin
            m_run = 0;
            m_pre = 0;
          end else begin
            m_lim = nf;
          end
        end
      end
    end
    if (ld) m_shadow = fv;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.cnt);
        check("tick", int'(tick), e.tick);
        check("running", int'(running), e.run);
      end
    end
  end

  task automatic cycle(input bit en, input bit st, input bit sp, input bit md,
                       input bit ld, input int fv, input int ps);
    exp_t e;
    @(negedge clk);
    #1;
    enable      = en;
    start       = st;
    stop        = sp;
    mode        = md;
    load        = ld;
    final_value = fv[W-1:0];
`ifdef TIMER_PRESCALE_EN
    prescale    = ps[PW-1:0];
`endif
    model_step(en, st, sp, md, ld, fv, ps);
    e.cnt  = m_cnt;
    e.tick = m_tick;
    e.run  = m_run;
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n, input int ps);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, ps);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_running"}, int'(running), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    enable = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; mode = 1'b0;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cur_ps;
    int fv;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;

    // periodic, final 3
    cycle(1, 0, 0, 0, 1, 3, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    run_cycles(13, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    run_cycles(2, 0);

    // one-shot, final 4, enable gap of two cycles
    cycle(1, 1, 0, 1, 1, 4, 0);
    run_cycles(2, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
    run_cycles(8, 0);

    // shadow reload: load 2 while count=1 of a final-5 period
    cycle(1, 1, 0, 0, 1, 5, 0);
    run_cycles(1, 0);
    cycle(1, 0, 0, 0, 1, 2, 0);
    run_cycles(12, 0);
    for (int i = 0; i < 8 && !(m_run != 0 && m_cnt == m_lim); i++) run_cycles(1, 0);
    cycle(1, 0, 0, 0, 1, 6, 0);
    run_cycles(10, 0);

    // control priority, restart, final 0
    cycle(1, 1, 1, 0, 0, 0, 0);
    run_cycles(2, 0);
    cycle(1, 1, 0, 0, 1, 7, 0);
    run_cycles(2, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    run_cycles(3, 0);
    cycle(1, 1, 0, 0, 1, 0, 0);
    run_cycles(5, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);

    // reset mid-run at count 5
    cycle(1, 1, 0, 0, 1, 9, 0);
    run_cycles(5, 0);
    do_reset();
    run_cycles(4, 0);

`ifdef TIMER_PRESCALE_EN
    cycle(1, 0, 0, 0, 1, 1, 2);
    cycle(1, 1, 0, 0, 0, 0, 2);
    run_cycles(14, 2);
    cycle(1, 0, 1, 0, 0, 0, 2);
    cycle(1, 1, 0, 0, 0, 0, 2);
    run_cycles(8, 2);
    cycle(1, 0, 1, 0, 0, 0, 2);
`endif

    cur_ps = 0;
    repeat (3000) begin
      if ($urandom_range(0, 63) == 0) cur_ps = $urandom_range(0, 3);
      fv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, fv, cur_ps);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_nbits_ctrl.md
Name: timer_nbits_ctrl

Overview:
Programmable N-bit interval timer. It is the successor to the fixed compare-and-wrap timer used for UART baud and bit timing. It adds start/stop control, periodic and one-shot modes, a shadowed (glitch-free) reload value, a count readback and a registered terminal tick. It sits between the UART control FSMs and the bit/baud logic, and is also used as a general-purpose interval timer.

Parameters:
WIDTH, 16, counter and compare width in bits (>=2)
PRESCALE_W, 8, prescaler width in bits; used only when TIMER_PRESCALE_EN is defined

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  count-advance qualifier; when 0, the counter and prescaler hold
start  input  1  single-cycle pulse: (re)start the timer
stop  input  1  single-cycle pulse: halt the timer; wins over start
mode  input  1  0 = periodic (auto-reload), 1 = one-shot; sampled at start
load  input  1  single-cycle pulse: capture final_value into the shadow register
final_value  input  WIDTH  terminal count value
prescale  input  PRESCALE_W  prescaler terminal value (port exists only with TIMER_PRESCALE_EN)
count  output  WIDTH  current counter value
tick  output  1  registered one-cycle pulse, one per completed period
running  output  1  high while in RUN

Behaviour:
- Reset (async, reset=0): count=0, tick=0, running=0, shadow=0, active_final=0, mode_q=0, state=IDLE.
- Registers: shadow (loaded by load), active_final (the value actually compared), mode_q (mode latched at start).
- load: shadow<=final_value on any cycle, in any state.
- next_final = load ? final_value : shadow. A same-cycle load is therefore seen immediately.
- FSM states: IDLE and RUN.
- IDLE:
  - count holds its last value.
  - On start (and no stop): count<=0, active_final<=next_final, mode_q<=mode, go to RUN.
- RUN, stop asserted: go to IDLE, count<=0, tick<=0. This applies regardless of start, enable and terminal count.
- RUN, start without stop: restart. count<=0, active_final<=next_final, mode_q<=mode, no tick.
- RUN, advance: an advance occurs when enable=1 and the prescaler terminal is reached (always true without the macro).
  - If count!=active_final: count<=count+1.
  - If count==active_final (wrap): count<=0 and tick<=1 on the next cycle.
    - mode_q=0: active_final<=next_final (reload at the boundary only) and stay in RUN.
    - mode_q=1: go to IDLE.
- tick is 0 on every cycle not following a wrap.
- Period = active_final+1 advances. With final_value=0, tick fires on every advance.
- Changing final_value without load never affects a running period.
- count never exceeds active_final. There is no overflow path; wrap-around is to 0 only.
- running = (state==RUN), registered.
- One-shot completion: running falls on the same edge on which tick rises.

Optional Feature:
Macro TIMER_PRESCALE_EN.
- Defined:
  - Adds the prescale port and a PRESCALE_W-bit prescaler counter pre_cnt, reset to 0.
  - In RUN with enable=1: if pre_cnt==prescale, then pre_cnt<=0 and the main counter advances; otherwise pre_cnt<=pre_cnt+1.
  - pre_cnt<=0 on start, stop and entry to IDLE.
  - prescale is sampled continuously.
  - Period = (active_final+1)*(prescale+1) enabled cycles.
- Not defined: no prescale port and no prescaler logic; the counter advances on every enabled RUN cycle.

Test Plan:
- Reset mid-run: assert reset with count=5 -> count, tick and running are 0 immediately (async), with no tick after release.
- Periodic: load final_value=3, start, mode=0, enable=1 -> tick pulses of 1 cycle, every 4 cycles, first tick 4 cycles after start; count sequence 0,1,2,3,0.
- One-shot with enable gap: final_value=4, mode=1, enable low for 2 cycles mid-count -> single tick 7 cycles after start, running falls with the tick, count holds at 0 afterward.
- Shadow reload: periodic with final 5, load final 2 at count=1 -> current period still ends at 5; the following periods are 3 cycles; a same-cycle load+wrap takes the new value.
- Control priority: start+stop together in RUN -> IDLE, count=0, no tick. Start at count=2 -> count restarts at 0. final_value=0 -> tick on every cycle.
- TIMER_PRESCALE_EN: prescale=2, final_value=1 -> tick every 6 enabled cycles; stop then start resets pre_cnt (first tick 6 cycles after start).
